// File: rtl/color_pattern_gen.sv
// color_pattern_gen
//   Pixel colour stage between the timing generator and the VGA DAC.
//   Normal mode registers the frame-buffer pixel onto the colour outputs.
//   Test mode renders one of five built-in patterns. The pattern index steps
//   on rising edges of next_test. Pattern 4 is a white bar that moves once
//   per frame.
// Ports:
//   clk, rst_        pixel clock, asynchronous active-low reset
//   test_mode        1 = test patterns, 0 = frame-buffer pass-through
//   next_test        level input; each rising edge advances the pattern
//   h_active/v_active  active-video flags from the timing generator
//   h_counter/v_counter  pixel / line counters (CNT_W bits)
//   current_pixel    frame-buffer pixel, packed {R,G,B}
//   red/green/blue   registered colour outputs (1-cycle latency)
//   pattern_idx      current test pattern 0..4
//   frame_count      completed frames, wraps 255 -> 0
module color_pattern_gen #(
  parameter int CW         = 4,
  parameter int CNT_W      = 10,
  parameter int H_START    = 160,
  parameter int H_ACTIVE   = 640,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              test_mode,
  input  logic              next_test,
  input  logic              h_active,
  input  logic              v_active,
  input  logic [CNT_W-1:0]  h_counter,
  input  logic [CNT_W-1:0]  v_counter,
  input  logic [3*CW-1:0]   current_pixel,
  output logic [CW-1:0]     red,
  output logic [CW-1:0]     green,
  output logic [CW-1:0]     blue,
  output logic [2:0]        pattern_idx,
  output logic [7:0]        frame_count
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int MBAR_W = 16;

  logic [CNT_W-1:0] x;
  logic             nt_q, va_q, rise, fe;
  logic [CNT_W-1:0] bar_pos;
  logic [CNT_W:0]   bar_next;
  logic [CNT_W+1:0] bar_end;
  logic [2:0]       bar_k;
  logic [2:0]       bar_rgb;
  logic [CNT_W-1:0] chk_x;
  logic [CNT_W-1:0] grad_x;
  logic             in_mbar;
  logic [CW-1:0]    r_n, g_n, b_n;
  logic             unused_bits;

  // x wraps when h_counter < H_START, which lands it above H_ACTIVE.
  assign x    = h_counter - CNT_W'(H_START);
  assign rise = next_test & ~nt_q;
  assign fe   = va_q & ~v_active;

  // Moving bar advance: wraps to 0 when the bar would run past the line end.
  assign bar_next = {1'b0, bar_pos} + (CNT_W+1)'(4);
  assign bar_end  = {1'b0, bar_next} + (CNT_W+2)'(MBAR_W);

  assign chk_x  = (x >> CHECK_LOG2) ^ (v_counter >> CHECK_LOG2);
  assign grad_x = x >> GRAD_SHIFT;
  assign in_mbar = ({1'b0, x} >= {1'b0, bar_pos}) &&
                   ({1'b0, x} <  ({1'b0, bar_pos} + (CNT_W+1)'(MBAR_W)));

  // Upper bits of the shifted terms have no consumer.
  assign unused_bits = ^{chk_x[CNT_W-1:1], grad_x[CNT_W-1:CW]};

  // Bar number from threshold comparisons rather than a divider.
  always_comb begin
    bar_k = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= CNT_W'(i * BAR_W)) bar_k = 3'(i);
    end
  end

  // Bar colours as {R,G,B} on/off bits.
  always_comb begin
    bar_rgb = 3'b000;
    case (bar_k)
      3'd0: bar_rgb = 3'b000;  // black
      3'd1: bar_rgb = 3'b111;  // white
      3'd2: bar_rgb = 3'b100;  // red
      3'd3: bar_rgb = 3'b110;  // yellow
      3'd4: bar_rgb = 3'b010;  // green
      3'd5: bar_rgb = 3'b011;  // cyan
      3'd6: bar_rgb = 3'b001;  // blue
      3'd7: bar_rgb = 3'b101;  // magenta
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (h_active && v_active) begin
      if (!test_mode) begin
        r_n = current_pixel[3*CW-1:2*CW];
        g_n = current_pixel[2*CW-1:CW];
        b_n = current_pixel[CW-1:0];
      end else begin
        case (pattern_idx)
          3'd0: begin
            if (x < CNT_W'(H_ACTIVE)) begin
              r_n = {CW{bar_rgb[2]}};
              g_n = {CW{bar_rgb[1]}};
              b_n = {CW{bar_rgb[0]}};
            end
          end
          3'd1: begin
            r_n = '0;
            g_n = '1;
            b_n = {1'b0, {(CW-1){1'b1}}};
          end
          3'd2: begin
            r_n = {CW{chk_x[0]}};
            g_n = {CW{chk_x[0]}};
            b_n = {CW{chk_x[0]}};
          end
          3'd3: begin
            r_n = grad_x[CW-1:0];
            g_n = grad_x[CW-1:0];
            b_n = grad_x[CW-1:0];
          end
          3'd4: begin
            r_n = {CW{in_mbar}};
            g_n = {CW{in_mbar}};
            b_n = {CW{in_mbar}};
          end
          default: begin
            r_n = '0;
            g_n = '0;
            b_n = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pattern_idx <= 3'd0;
      frame_count <= 8'd0;
      bar_pos     <= '0;
      nt_q        <= 1'b0;
      va_q        <= 1'b0;
    end else begin
      red   <= r_n;
      green <= g_n;
      blue  <= b_n;
      nt_q  <= next_test;
      va_q  <= v_active;
      // Pattern stepping and frame-end bookkeeping are independent and may
      // both fire on the same edge.
      if (rise && test_mode) begin
        pattern_idx <= (pattern_idx == 3'd4) ? 3'd0 : pattern_idx + 3'd1;
      end
      if (fe) begin
        frame_count <= frame_count + 8'd1;
        if (bar_end > (CNT_W+2)'(H_ACTIVE)) bar_pos <= '0;
        else                                bar_pos <= bar_next[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_color_pattern_gen.sv
// Testbench for color_pattern_gen: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a reference model.
module tb_color_pattern_gen;

  localparam int CW = 4;
  localparam int CNT_W = 10;
  localparam int H_START = 160;
  localparam int H_ACTIVE = 640;
  localparam int EW = 3*CW + 3 + 8;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_ = 1'b1;
  logic              test_mode = 1'b0;
  logic              next_test = 1'b0;
  logic              h_active = 1'b0;
  logic              v_active = 1'b0;
  logic [CNT_W-1:0]  h_counter = '0;
  logic [CNT_W-1:0]  v_counter = '0;
  logic [3*CW-1:0]   current_pixel = '0;
  logic [CW-1:0]     red, green, blue;
  logic [2:0]        pattern_idx;
  logic [7:0]        frame_count;

  always #5 clk = ~clk;

  color_pattern_gen dut (
    .clk(clk), .rst_(rst_), .test_mode(test_mode), .next_test(next_test),
    .h_active(h_active), .v_active(v_active), .h_counter(h_counter),
    .v_counter(v_counter), .current_pixel(current_pixel),
    .red(red), .green(green), .blue(blue),
    .pattern_idx(pattern_idx), .frame_count(frame_count)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  int m_idx, m_fc, m_bp;
  bit m_nt, m_va;

  function automatic logic [11:0] ref_rgb(bit tm, bit ha, bit va, int h,
                                          int v, logic [11:0] pix, int idx,
                                          int bp);
    int x;
    logic [2:0] t;
    logic [3:0] g;
    x = h - H_START;
    if (x < 0) x += 1024;
    if (!ha || !va) return 12'h000;
    if (!tm) return pix;
    case (idx)
      0: begin
        if (x >= H_ACTIVE) return 12'h000;
        case (x / (H_ACTIVE / 8))
          0: t = 3'b000; 1: t = 3'b111; 2: t = 3'b100; 3: t = 3'b110;
          4: t = 3'b010; 5: t = 3'b011; 6: t = 3'b001; default: t = 3'b101;
        endcase
        return {{4{t[2]}}, {4{t[1]}}, {4{t[0]}}};
      end
      1: return 12'h0F7;
      2: return ((((x >> 5) ^ (v >> 5)) & 1) == 1) ? 12'hFFF : 12'h000;
      3: begin
        g = 4'((x >> 5) % 16);
        return {g, g, g};
      end
      4: return (x >= bp && x < bp + 16) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name);
    logic [EW-1:0] e, a;
    e = exp_q.pop_front();
    a = {red, green, blue, pattern_idx, frame_count};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got rgb=%03h idx=%0d fc=%0d expected rgb=%03h idx=%0d fc=%0d at %0t",
               name, a[EW-1:11], a[10:8], a[7:0], e[EW-1:11], e[10:8], e[7:0], $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs, advances the model and checks the outputs
  // just after the sampling edge.
  task automatic apply(input bit tm, input bit nt, input bit ha, input bit va,
                       input int h, input int v, input logic [11:0] pix);
    logic [11:0] rgb;
    test_mode = tm; next_test = nt; h_active = ha; v_active = va;
    h_counter = CNT_W'(h); v_counter = CNT_W'(v); current_pixel = pix;
    @(posedge clk);
    rgb = ref_rgb(tm, ha, va, h, v, pix, m_idx, m_bp);
    if (nt && !m_nt && tm) m_idx = (m_idx + 1) % 5;
    if (m_va && !va) begin
      m_fc = (m_fc + 1) % 256;
      m_bp = m_bp + 4;
      if (m_bp + 16 > H_ACTIVE) m_bp = 0;
    end
    m_nt = nt;
    m_va = va;
    exp_q.push_back({rgb, 3'(m_idx), 8'(m_fc)});
    #1;
    check_out("model");
  endtask

  task automatic do_reset(input bit nt_lvl);
    #2 rst_ = 1'b0;
    #1;
    check_val("rst_red", int'(red), 0);
    check_val("rst_green", int'(green), 0);
    check_val("rst_blue", int'(blue), 0);
    check_val("rst_idx", int'(pattern_idx), 0);
    check_val("rst_fc", int'(frame_count), 0);
    next_test = nt_lvl;
    m_idx = 0; m_fc = 0; m_bp = 0; m_nt = 1'b0; m_va = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic pulse(input bit tm);
    apply(tm, 1'b1, 1'b1, 1'b1, 300, 10, 12'h123);
    apply(tm, 1'b0, 1'b1, 1'b1, 300, 10, 12'h123);
  endtask

  task automatic frame(input bit tm);
    apply(tm, 1'b0, 1'b1, 1'b1, $urandom_range(160, 799), 5, 12'h000);
    apply(tm, 1'b0, 1'b1, 1'b1, $urandom_range(160, 799), 6, 12'h000);
    apply(tm, 1'b0, 1'b1, 1'b0, 100, 480, 12'h000);
  endtask

  task automatic probe(input int x, input int exp_r);
    apply(1'b1, 1'b0, 1'b1, 1'b1, H_START + x, 3, 12'h000);
    check_val("bar_px", int'(red), exp_r);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          tm, nt, ha, va;
    int          h, v;
    logic [11:0] pix;
    logic [11:0] e_rgb;
    int          e_idx;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // pass-through and blanking
    vecs.push_back('{0, 0, 1, 1, 160, 0, 12'hA53, 12'hA53, 0});
    vecs.push_back('{0, 0, 0, 1, 160, 0, 12'hA53, 12'h000, 0});
    // colour bars
    vecs.push_back('{1, 0, 1, 1, 239, 0, 12'h000, 12'h000, 0});
    vecs.push_back('{1, 0, 1, 1, 240, 0, 12'h000, 12'hFFF, 0});
    vecs.push_back('{1, 0, 1, 1, 799, 0, 12'h000, 12'hF0F, 0});
    vecs.push_back('{1, 0, 1, 1, 800, 0, 12'h000, 12'h000, 0});
    vecs.push_back('{1, 0, 1, 1, 300, 0, 12'h000, 12'hFFF, 0});
    vecs.push_back('{1, 0, 1, 1, 400, 0, 12'h000, 12'hFF0, 0});
    // step to solid
    vecs.push_back('{1, 1, 1, 1, 160, 0, 12'h000, 12'h000, 1});
    vecs.push_back('{1, 0, 1, 1, 160, 0, 12'h000, 12'h0F7, 1});
    // step to checkerboard
    vecs.push_back('{1, 1, 1, 1, 160, 0, 12'h000, 12'h0F7, 2});
    vecs.push_back('{1, 0, 1, 1, 160, 0, 12'h000, 12'h000, 2});
    vecs.push_back('{1, 0, 1, 1, 192, 0, 12'h000, 12'hFFF, 2});
    // step to gradient (wraps after MAX)
    vecs.push_back('{1, 1, 1, 1, 192, 0, 12'h000, 12'hFFF, 3});
    vecs.push_back('{1, 0, 1, 1, 704, 0, 12'h000, 12'h111, 3});
    // step to moving bar at bar_pos 0
    vecs.push_back('{1, 1, 1, 1, 160, 0, 12'h000, 12'h000, 4});
    vecs.push_back('{1, 0, 1, 1, 160, 0, 12'h000, 12'hFFF, 4});
    vecs.push_back('{1, 0, 1, 1, 175, 0, 12'h000, 12'hFFF, 4});
    vecs.push_back('{1, 0, 1, 1, 176, 0, 12'h000, 12'h000, 4});
    // wrap back to bars; blanking in test mode
    vecs.push_back('{1, 1, 1, 1, 176, 0, 12'h000, 12'h000, 0});
    vecs.push_back('{1, 0, 1, 1, 240, 0, 12'h000, 12'hFFF, 0});
    vecs.push_back('{1, 0, 0, 1, 240, 0, 12'h000, 12'h000, 0});
  end

  // ---------------- main test ----------------
  initial begin
    bit r_nt, r_va;
    #1;
    do_reset(1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].tm, vecs[i].nt, vecs[i].ha, vecs[i].va, vecs[i].h,
            vecs[i].v, vecs[i].pix);
      check_val($sformatf("vec%0d_rgb", i), int'({red, green, blue}),
                int'(vecs[i].e_rgb));
      check_val($sformatf("vec%0d_idx", i), int'(pattern_idx), vecs[i].e_idx);
    end

    // wide pulse advances once
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 1'b1, 1'b1, 300, 0, 12'h000);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 300, 0, 12'h000);
    check_val("wide_pulse_idx", int'(pattern_idx), 1);
    // pulses ignored in pass-through
    for (int i = 0; i < 3; i++) pulse(1'b0);
    check_val("tm0_pulse_idx", int'(pattern_idx), 1);
    for (int i = 0; i < 3; i++) pulse(1'b1);
    check_val("to_bar_idx", int'(pattern_idx), 4);
    check_val("pre_frames_fc", int'(frame_count), 0);

    // moving bar across 160 frames
    for (int f = 1; f <= 160; f++) begin
      frame(1'b1);
      if (f == 156) begin
        probe(624, 15);
        probe(639, 15);
        probe(623, 0);
      end
      if (f == 157) probe(0, 15);
    end
    check_val("fc_160", int'(frame_count), 160);
    probe(11, 0);
    probe(12, 15);
    probe(27, 15);
    probe(28, 0);

    // reset mid-frame with idx 3 and 7 frames counted
    do_reset(1'b0);
    for (int f = 0; f < 7; f++) frame(1'b1);
    for (int i = 0; i < 3; i++) pulse(1'b1);
    check_val("pre_rst_fc", int'(frame_count), 7);
    check_val("pre_rst_idx", int'(pattern_idx), 3);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 704, 0, 12'h000);
    check_val("pre_rst_rgb", int'({red, green, blue}), 12'h111);
    do_reset(1'b0);

    // rise coincident with frame end
    apply(1'b1, 1'b0, 1'b1, 1'b1, 300, 0, 12'h000);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 300, 0, 12'h000);
    check_val("coinc_idx", int'(pattern_idx), 1);
    check_val("coinc_fc", int'(frame_count), 1);

    // next_test already high at reset release counts as a rise
    test_mode = 1'b1;
    do_reset(1'b1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 300, 0, 12'h000);
    check_val("nt_high_at_rst_idx", int'(pattern_idx), 1);

    // randomized stimulus against the model
    do_reset(1'b0);
    r_nt = 1'b0;
    r_va = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) r_nt = ~r_nt;
      if ($urandom_range(0, 19) == 0) r_va = ~r_va;
      apply($urandom_range(0, 3) != 0, r_nt, $urandom_range(0, 4) != 0, r_va,
            $urandom_range(100, 850), $urandom_range(0, 524),
            12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_pattern_gen.md
# color_pattern_gen

Parametrised pixel colour stage of the display controller. It sits between the timing generator (h/v counters, active flags) and the VGA DAC pins. In normal mode it registers the frame-buffer pixel onto the colour outputs. In test mode it renders one of five built-in test patterns, chosen by a pattern index that steps on edges of `next_test`; one pattern animates once per frame.

## Interface
Parameters:
- `CW`, 4: bits per colour channel; `current_pixel` is 3*CW wide, packed {R,G,B}.
- `CNT_W`, 10: width of `h_counter`/`v_counter`.
- `H_START`, 160: `h_counter` value of the first active pixel.
- `H_ACTIVE`, 640: active pixels per line; must be a multiple of 8.
- `CHECK_LOG2`, 5: checkerboard square side is 2^CHECK_LOG2 pixels.
- `GRAD_SHIFT`, 5: gradient step width is 2^GRAD_SHIFT pixels.

Ports:
- `clk`  in  1  pixel clock.
- `rst_`  in  1  asynchronous, active-low reset.
- `test_mode`  in  1  1 = test patterns, 0 = pass-through.
- `next_test`  in  1  level input; each rising edge advances the pattern.
- `h_active`  in  1  horizontal active period.
- `v_active`  in  1  vertical active period.
- `h_counter`  in  CNT_W  pixel count within the line.
- `v_counter`  in  CNT_W  line count.
- `current_pixel`  in  3*CW  frame-buffer pixel {R,G,B}.
- `red`, `green`, `blue`  out  CW each  registered colour outputs.
- `pattern_idx`  out  3  current test pattern, 0..4.
- `frame_count`  out  8  completed frames, wraps 255→0.

## Operation
- Definitions: x = h_counter − H_START, computed CNT_W bits wide. MAX = all-ones CW. BAR_W = H_ACTIVE/8.
- Blanking: when `h_active`=0 or `v_active`=0, R/G/B = 0.
- Pass-through (`test_mode`=0, active): R,G,B = `current_pixel`[3CW-1:2CW], [2CW-1:CW], [CW-1:0].
- Test mode (active), by `pattern_idx`:
  - 0, colour bars. Bar k = x/BAR_W, using comparisons only, no divider. Bars in order: black, white, red, yellow, green, cyan, blue, magenta. Channels are 0 or MAX. x ≥ H_ACTIVE gives black.
  - 1, solid: R=0, G=MAX, B=MAX>>1.
  - 2, checkerboard: white (all MAX) when bit0 of ((x>>CHECK_LOG2) ^ (v_counter>>CHECK_LOG2)) is 1, else black.
  - 3, grey gradient: all channels = (x>>GRAD_SHIFT) truncated to CW bits. The ramp wraps to 0 after MAX.
  - 4, moving bar: white when bar_pos ≤ x < bar_pos+16, else black.
- Edge detect: `next_test` is registered as nt_q. rise = next_test & ~nt_q.
  - When rise and `test_mode`=1: `pattern_idx` increments, with 4→0 wrap.
  - When `test_mode`=0, rises are ignored and `pattern_idx` holds.
  - Edges are honoured during blanking too.
- Frame end: `v_active` is registered as va_q. fe = va_q & ~v_active. On fe:
  - `frame_count`++.
  - bar_pos += 4; if the new value + 16 > H_ACTIVE, bar_pos = 0 instead.
  - This runs in both modes.
- Simultaneous rise and fe: both updates apply in the same cycle.

## Timing
- All outputs are registered. R/G/B reflect the inputs sampled at the previous clk edge: 1-cycle latency.
- A pattern change is visible on R/G/B starting the cycle after `pattern_idx` updates. `pattern_idx` updates on the edge where rise is sampled, so the change is 2 clocks after `next_test` goes high.
- Holding `next_test` high advances `pattern_idx` once only.
- bar_pos and `frame_count` update on the clk edge where fe is detected, i.e. the first clock with `v_active`=0 after an active frame.
- Reset, asynchronous and possibly mid-frame: R/G/B=0, `pattern_idx`=0, `frame_count`=0, bar_pos=0, nt_q=0, va_q=0. First output after release is 1 cycle later.
- After reset, a `next_test` already high counts as a rise on the first clock.

## Test plan
- Pass-through: test_mode=0, active, current_pixel=12'hA53 → next cycle R=A, G=5, B=3. Drop h_active → next cycle 0/0/0.
- Bars: test_mode=1, idx 0, sweep h_counter 160..799.
  - h=239 → 0/0/0; h=240 → F/F/F; h=799 → F/0/F.
  - h=800 (x=640) → black.
- Pattern stepping: five single-cycle next_test pulses → pattern_idx 1,2,3,4,0. A 10-cycle-wide pulse → one step only. Pulses with test_mode=0 → idx unchanged.
- Checker/gradient: idx 2, v=0, h=160 → black; h=192 → white. idx 3, h=160+32*17 → all channels 1 (wrap).
- Moving bar: idx 4, run 160 frames → frame_count=160, bar_pos wraps to 0 after 624. Pixels at x=bar_pos..bar_pos+15 white, x=bar_pos+16 black.
- Reset mid-frame with idx=3, frame_count=7 → all outputs 0 asynchronously. next_test rise coincident with fe → both idx and frame_count update.
